// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache request arbiter and its picker.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } arb_state_t;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int cand;
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache_controller between NUM_REQ requesters.
// Optional BUSY watchdog enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_type,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          resp_err,
  output logic                          ctl_req_valid,
  output logic                          ctl_req_type,
  output logic [ADDR_WIDTH-1:0]         ctl_addr,
  output logic [DATA_WIDTH-1:0]         ctl_wdata,
  input  logic                          ctl_done,
  input  logic [DATA_WIDTH-1:0]         ctl_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("cache_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, owner, win_idx;
  logic [NUM_REQ-1:0] grant;
  logic               any_req, tmo_evt, busy_end;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (win_idx)
  );

  assign any_req = |req_valid;
  // Gated by rst so req_ready is quiet while reset is held.
  assign req_ready = (state == IDLE && rst) ? grant : '0;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == BUSY) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Fires on the edge where the count reaches TIMEOUT_CYCLES; ctl_done wins a tie.
  assign tmo_evt = (state == BUSY) && !ctl_done && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_evt = 1'b0;
`endif

  assign busy_end = ctl_done || tmo_evt;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req)  state_nxt = BUSY;
      BUSY:    if (busy_end) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr        <= '0;
      owner         <= '0;
      ctl_req_valid <= 1'b0;
      ctl_req_type  <= REQ_READ;
      ctl_addr      <= '0;
      ctl_wdata     <= '0;
      resp_valid    <= '0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner         <= win_idx;
            ctl_req_valid <= 1'b1;
            ctl_req_type  <= req_type[win_idx];
            ctl_addr      <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ctl_wdata     <= req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        BUSY: begin
          if (busy_end) begin
            // Clearing the ctl_* fields keeps every output at zero once back in IDLE.
            ctl_req_valid <= 1'b0;
            ctl_req_type  <= REQ_READ;
            ctl_addr      <= '0;
            ctl_wdata     <= '0;
            resp_valid    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
            resp_rdata    <= (ctl_done && ctl_req_type == REQ_READ) ? ctl_rdata : '0;
            resp_err      <= !ctl_done;
          end
        end
        RESPOND: begin
          resp_valid <= '0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          rr_ptr     <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter: vector table plus response scoreboard.
module tb_cache_req_arbiter;

  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_type, req_ready, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   resp_rdata, ctl_wdata, ctl_rdata;
  logic            resp_err, ctl_req_valid, ctl_req_type, ctl_done;
  logic [AW-1:0]   ctl_addr;

  cache_req_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ctl_req_valid(ctl_req_valid), .ctl_req_type(ctl_req_type), .ctl_addr(ctl_addr),
    .ctl_wdata(ctl_wdata), .ctl_done(ctl_done), .ctl_rdata(ctl_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  rv;
    logic [N-1:0]  rtype;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] w0, w1;
    logic [DW-1:0] rdata;
    int            delay;   // BUSY cycles before ctl_done; -1 = never
    bit            hold;    // keep req_valid asserted after acceptance
    logic [N-1:0]  grant;
    logic          etype;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewdata;
    logic [DW-1:0] erdata;
    logic          eerr;
  } vec_t;

  typedef struct {
    logic [N-1:0]  grant;
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    failures = 0;
  int    n_resp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every response the DUT produces is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && resp_valid !== '0) begin
      n_resp++;
      if (sb.size() == 0) begin
        check("resp_unexpected", 64'(resp_valid), 64'd0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        check("resp_port", 64'(resp_valid), 64'(e.grant));
        check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
        check("resp_err", 64'(resp_err), 64'(e.err));
      end
    end
  end

  task automatic do_txn(input vec_t v);
    @(negedge clk);
    check("idle_ctl_valid", 64'(ctl_req_valid), 64'd0);
    check("idle_resp_valid", 64'(resp_valid), 64'd0);
    req_valid = v.rv;
    req_type  = v.rtype;
    req_addr  = {v.a1, v.a0};
    req_wdata = {v.w1, v.w0};
    #1;
    check("req_ready", 64'(req_ready), 64'(v.grant));
    sb.push_back('{grant: v.grant, rdata: v.erdata, err: v.eerr});
    @(negedge clk);
    if (!v.hold) req_valid = '0;
    check("busy_ctl_valid", 64'(ctl_req_valid), 64'd1);
    check("busy_ctl_type", 64'(ctl_req_type), 64'(v.etype));
    check("busy_ctl_addr", 64'(ctl_addr), 64'(v.eaddr));
    check("busy_ctl_wdata", 64'(ctl_wdata), 64'(v.ewdata));
    check("busy_req_ready", 64'(req_ready), 64'd0);
    if (v.delay >= 0) begin
      repeat (v.delay) begin
        @(negedge clk);
        check("busy_hold_valid", 64'(ctl_req_valid), 64'd1);
        check("busy_hold_addr", 64'(ctl_addr), 64'(v.eaddr));
      end
      ctl_done  = 1'b1;
      ctl_rdata = v.rdata;
      @(negedge clk);
      ctl_done  = 1'b0;
      ctl_rdata = $urandom;
    end else begin
      repeat (TMO - 1) begin
        @(negedge clk);
        check("tmo_busy_valid", 64'(ctl_req_valid), 64'd1);
      end
      @(negedge clk);
    end
    check("respond_timing", 64'(resp_valid), 64'(v.grant));
    check("respond_ctl_valid", 64'(ctl_req_valid), 64'd0);
    check("respond_req_ready", 64'(req_ready), 64'd0);
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    vec_t v;
    rst = 1'b0; req_valid = '1; req_type = '0; req_addr = '0; req_wdata = '0;
    ctl_done = 1'b0; ctl_rdata = '0;

    // rv, type, a0, a1, w0, w1, rdata, delay, hold, grant, etype, eaddr, ewdata, erdata, eerr
    vecs[0] = '{2'b01, 2'b00, 32'h100, 32'h0,   32'h0, 32'h0,        32'hDEADBEEF, 2, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1] = '{2'b10, 2'b10, 32'h0,   32'h200, 32'h0, 32'h12345678, 32'hCAFEF00D, 3, 1'b0, 2'b10, 1'b1, 32'h200, 32'h12345678, 32'h0,        1'b0};
    vecs[2] = '{2'b11, 2'b00, 32'h300, 32'h400, 32'h0, 32'h0,        32'h11110000, 0, 1'b1, 2'b01, 1'b0, 32'h300, 32'h0,        32'h11110000, 1'b0};
    vecs[3] = '{2'b11, 2'b00, 32'h300, 32'h400, 32'h0, 32'h0,        32'h22220001, 1, 1'b1, 2'b10, 1'b0, 32'h400, 32'h0,        32'h22220001, 1'b0};
    vecs[4] = '{2'b11, 2'b00, 32'h300, 32'h400, 32'h0, 32'h0,        32'h33330000, 0, 1'b1, 2'b01, 1'b0, 32'h300, 32'h0,        32'h33330000, 1'b0};
    vecs[5] = '{2'b11, 2'b00, 32'h300, 32'h400, 32'h0, 32'h0,        32'h44440001, 2, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        32'h44440001, 1'b0};
    vecs[6] = '{2'b10, 2'b00, 32'h0,   32'h500, 32'h0, 32'h0,        32'h55550001, 1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0,        32'h55550001, 1'b0};
    vecs[7] = '{2'b01, 2'b01, 32'h600, 32'h0,   32'hA5A5A5A5, 32'h0, 32'h66660000, 0, 1'b0, 2'b01, 1'b1, 32'h600, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[8] = '{2'b01, 2'b00, 32'h700, 32'h0,   32'h0, 32'h0,        32'h77770000, 4, 1'b0, 2'b01, 1'b0, 32'h700, 32'h0,        32'h77770000, 1'b0};

    // Reset state, with requests already raised
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_ctl_valid", 64'(ctl_req_valid), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_ctl_addr", 64'(ctl_addr), 64'd0);
    req_valid = '0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle_ctl", 64'(ctl_req_valid), 64'd0);
    check("post_rst_idle_rdata", 64'(resp_rdata), 64'd0);

    for (int i = 0; i < 9; i++) do_txn(vecs[i]);
    req_valid = '0;

    // Request arriving during BUSY (rr_ptr=1 here; port 0 alone still wins)
    @(negedge clk);
    req_valid = 2'b01; req_addr = {32'h0, 32'h800}; req_type = 2'b00;
    #1 check("midbusy_first_ready", 64'(req_ready), 64'b01);
    sb.push_back('{grant: 2'b01, rdata: 32'hA5A50001, err: 1'b0});
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    req_valid = 2'b10; req_addr = {32'h900, 32'h800}; req_wdata = '0;
    #1 check("midbusy_ready_busy", 64'(req_ready), 64'd0);
    ctl_done = 1'b1; ctl_rdata = 32'hA5A50001;
    @(negedge clk);
    ctl_done = 1'b0;
    check("midbusy_ready_respond", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("midbusy_ready_idle", 64'(req_ready), 64'b10);
    sb.push_back('{grant: 2'b10, rdata: 32'hA5A50002, err: 1'b0});
    @(negedge clk);
    req_valid = '0;
    check("midbusy_second_addr", 64'(ctl_addr), 64'h900);
    ctl_done = 1'b1; ctl_rdata = 32'hA5A50002;
    @(negedge clk);
    ctl_done = 1'b0;
    check("midbusy_second_resp", 64'(resp_valid), 64'b10);

    // ctl_done while IDLE must be ignored
    @(negedge clk);
    ctl_done = 1'b1;
    @(negedge clk);
    ctl_done = 1'b0;
    check("idle_done_no_resp", 64'(resp_valid), 64'd0);
    check("idle_done_no_ctl", 64'(ctl_req_valid), 64'd0);

    // Reset mid-BUSY: first bring rr_ptr to 1, then start port 0 and reset
    do_txn(vecs[7]);
    @(negedge clk);
    req_valid = 2'b01; req_addr = {32'h0, 32'hB00}; req_type = 2'b00;
    #1 check("rstbusy_ready", 64'(req_ready), 64'b01);
    @(negedge clk);
    req_valid = 2'b11;
    check("rstbusy_ctl_before", 64'(ctl_req_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rstbusy_ctl_valid", 64'(ctl_req_valid), 64'd0);
    check("rstbusy_ctl_addr", 64'(ctl_addr), 64'd0);
    check("rstbusy_req_ready", 64'(req_ready), 64'd0);
    check("rstbusy_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rstbusy_rr_reset", 64'(req_ready), 64'b01);
    req_valid = 2'b10;
    #1 check("rstbusy_port1_ready", 64'(req_ready), 64'b10);
    req_valid = '0;
    v = vecs[6];
    v.rdata = 32'hC0DE0001; v.erdata = 32'hC0DE0001;
    do_txn(v);
    req_valid = '0;

`ifdef CACHE_ARB_TIMEOUT_EN
    v = vecs[0];
    v.delay = -1; v.erdata = 32'h0; v.eerr = 1'b1;
    do_txn(v);
    v = vecs[6];
    v.delay = TMO - 1; v.rdata = 32'h8888_0008; v.erdata = 32'h8888_0008; v.eerr = 1'b0;
    do_txn(v);
    req_valid = '0;
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("resp_seen", 64'(n_resp > 0), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
